// File: rtl/mram_access_ctrl_pkg.sv
// Shared types and default timing for the MRAM access controller.
// State encoding, interval-counter width and default bus-cycle timings.
package mram_access_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_WR_PULSE  = 3'd2,
    ST_RD_ACCESS = 3'd3,
    ST_RD_HOLD   = 3'd4,
    ST_RECOVER   = 3'd5
  } state_t;

  localparam int CNT_W       = 8;
  localparam int DEF_ADDR_W  = 20;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_LEN_W   = 8;
  localparam int DEF_T_SETUP = 1;
  localparam int DEF_T_WR    = 4;
  localparam int DEF_T_RD    = 4;
  localparam int DEF_T_REC   = 1;

endpackage

// File: rtl/mram_wait_counter.sv
// Loadable down-counter shared by every bus-cycle interval.
// Loading N-1 makes the zero flag rise after exactly N cycles in a state.
module mram_wait_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mram_access_ctrl.sv
// Turns burst read/write requests plus a word stream into timed MRAM bus cycles.
// Strobes are decoded from the registered state so reset releases them at once.
module mram_access_ctrl
  import mram_access_ctrl_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_WR    = DEF_T_WR,
  parameter int T_RD    = DEF_T_RD,
  parameter int T_REC   = DEF_T_REC
) (
  input  logic              FPGA_clk,
  input  logic              FPGA_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [1:0]        cmd_be,
  input  logic              abort,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] mram_addr,
  output logic [DATA_W-1:0] mram_dq_out,
  output logic              mram_dq_oe,
  input  logic [DATA_W-1:0] mram_dq_in,
  output logic              chip_en,
  output logic              read_en,
  output logic              write_en,
  output logic              lb_en,
  output logic              ub_en
);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_WR    = CNT_W'(T_WR - 1);
  localparam logic [CNT_W-1:0] LD_RD    = CNT_W'(T_RD - 1);
  localparam logic [CNT_W-1:0] LD_REC   = CNT_W'(T_REC - 1);

  state_t             state, state_nxt;
  logic               cnt_load, cnt_zero;
  logic [CNT_W-1:0]   cnt_val;
  logic               dir_wr, have_word, abort_lat, done_r, aborted_r, rd_valid_r;
  logic [LEN_W-1:0]   len_r;
  logic [1:0]         be_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [DATA_W-1:0]  wr_word, rd_word;
  logic               abort_eff, last_word, cmd_take, wr_take, rd_sample, rec_exit;

  mram_wait_counter #(.CNT_W(CNT_W)) u_wait (
    .clk      (FPGA_clk),
    .rst_n    (FPGA_rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  assign abort_eff = abort_lat | abort;
  assign last_word = (len_r == '0) || abort_eff;
  assign cmd_take  = cmd_valid && cmd_ready;
  assign wr_take   = wr_valid && wr_ready;
  assign rd_sample = (state == ST_RD_ACCESS) && cnt_zero;
  assign rec_exit  = (state == ST_RECOVER) && cnt_zero;

  always_ff @(posedge FPGA_clk or negedge FPGA_rst) begin
    if (!FPGA_rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = LD_SETUP;
    case (state)
      ST_IDLE: if (cmd_take) begin
        state_nxt = ST_SETUP;
        cnt_load  = 1'b1;
      end
      ST_SETUP: if (dir_wr) begin
        if (wr_take) begin
          cnt_load = 1'b1;
        end else if (have_word && cnt_zero) begin
          state_nxt = ST_WR_PULSE;
          cnt_load  = 1'b1;
          cnt_val   = LD_WR;
        end else if (!have_word && abort_eff) begin
          // Starved with nothing on the bus: safe to wind down without a strobe.
          state_nxt = ST_RECOVER;
          cnt_load  = 1'b1;
          cnt_val   = LD_REC;
        end
      end else if (cnt_zero) begin
        state_nxt = ST_RD_ACCESS;
        cnt_load  = 1'b1;
        cnt_val   = LD_RD;
      end
      ST_WR_PULSE: if (cnt_zero) begin
        state_nxt = ST_RECOVER;
        cnt_load  = 1'b1;
        cnt_val   = LD_REC;
      end
      ST_RD_ACCESS: if (cnt_zero) state_nxt = ST_RD_HOLD;
      ST_RD_HOLD: if (rd_ready || abort_eff) begin
        state_nxt = ST_RECOVER;
        cnt_load  = 1'b1;
        cnt_val   = LD_REC;
      end
      ST_RECOVER: if (cnt_zero) begin
        state_nxt = last_word ? ST_IDLE : ST_SETUP;
        cnt_load  = !last_word;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != ST_IDLE);
    cmd_ready   = (state == ST_IDLE) && !done_r;
    wr_ready    = (state == ST_SETUP) && dir_wr && !have_word;
    chip_en     = (state == ST_IDLE);
    read_en     = (state != ST_RD_ACCESS);
    write_en    = (state != ST_WR_PULSE);
    lb_en       = (state == ST_IDLE) ? 1'b1 : ~be_r[0];
    ub_en       = (state == ST_IDLE) ? 1'b1 : ~be_r[1];
    mram_dq_oe  = (state != ST_IDLE) && dir_wr && have_word;
    mram_dq_out = wr_word;
    mram_addr   = addr_r;
    rd_data     = rd_word;
    rd_valid    = rd_valid_r;
    done        = done_r;
    aborted     = done_r && aborted_r;
  end

  always_ff @(posedge FPGA_clk or negedge FPGA_rst) begin
    if (!FPGA_rst) begin
      dir_wr     <= 1'b0;
      len_r      <= '0;
      be_r       <= '0;
      addr_r     <= '0;
      have_word  <= 1'b0;
      abort_lat  <= 1'b0;
      done_r     <= 1'b0;
      aborted_r  <= 1'b0;
      rd_valid_r <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      if (state == ST_IDLE)
        abort_lat <= 1'b0;
      else if (abort)
        abort_lat <= 1'b1;
      if (cmd_take) begin
        dir_wr <= cmd_write;
        len_r  <= cmd_len;
        be_r   <= cmd_be;
        addr_r <= cmd_addr;
      end
      if (wr_take)
        have_word <= 1'b1;
      if (rd_sample)
        rd_valid_r <= 1'b1;
      else if ((state == ST_RD_HOLD) && (rd_ready || abort_eff))
        rd_valid_r <= 1'b0;
      if (rec_exit) begin
        have_word <= 1'b0;
        if (last_word) begin
          done_r    <= 1'b1;
          aborted_r <= abort_eff;
        end else begin
          addr_r <= addr_r + 1'b1;
          len_r  <= len_r - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge FPGA_clk) begin
    if (wr_take)
      wr_word <= wr_data;
    if (rd_sample)
      rd_word <= mram_dq_in;
  end

endmodule

// File: tb/tb_mram_access_ctrl.sv
// Directed bench for mram_access_ctrl: reset, single write, wrapping read burst,
// read back-pressure, write starvation and mid-pulse abort.
module tb_mram_access_ctrl;

  logic        FPGA_clk = 1'b0;
  logic        FPGA_rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [19:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [1:0]  cmd_be;
  logic        abort;
  logic [15:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid, rd_ready;
  logic        busy, done, aborted;
  logic [19:0] mram_addr;
  logic [15:0] mram_dq_out, mram_dq_in;
  logic        mram_dq_oe;
  logic        chip_en, read_en, write_en, lb_en, ub_en;

  int n_checks = 0;
  int n_errors = 0;

  always #5 FPGA_clk = ~FPGA_clk;

  // Memory model: every word reads back as the low 16 bits of its address.
  assign mram_dq_in = mram_addr[15:0];

  mram_access_ctrl dut (
    .FPGA_clk(FPGA_clk), .FPGA_rst(FPGA_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_be(cmd_be), .abort(abort),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .aborted(aborted),
    .mram_addr(mram_addr), .mram_dq_out(mram_dq_out), .mram_dq_oe(mram_dq_oe),
    .mram_dq_in(mram_dq_in), .chip_en(chip_en), .read_en(read_en),
    .write_en(write_en), .lb_en(lb_en), .ub_en(ub_en)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge FPGA_clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [19:0] a, input logic [7:0] len,
                          input logic [1:0] be);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len; cmd_be = be;
    tick();
    cmd_valid = 1'b0;
    chk("busy_after_cmd", busy, 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 200) begin tick(); n++; end
    chk(tag, done, 1);
  endtask

  task automatic wait_rd(input string tag, output int n);
    n = 0;
    while (!rd_valid && n < 200) begin tick(); n++; end
    chk(tag, rd_valid, 1);
  endtask

  task automatic wait_wr_ready(input string tag);
    int n = 0;
    while (!wr_ready && n < 200) begin tick(); n++; end
    chk(tag, wr_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int lat;
    logic [15:0] exp_rd [4];
    exp_rd[0] = 16'hFFFE; exp_rd[1] = 16'hFFFF; exp_rd[2] = 16'h0000; exp_rd[3] = 16'h0001;

    FPGA_rst = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    cmd_be = 2'b00; abort = 0; wr_data = '0; wr_valid = 0; rd_ready = 0;
    tick(); tick();
    chk("rst_chip_en", chip_en, 1);
    chk("rst_strobes", {read_en, write_en, lb_en, ub_en}, 4'hF);
    chk("rst_oe", mram_dq_oe, 0);
    chk("rst_addr", mram_addr, 0);
    chk("rst_status", {rd_valid, done, aborted, busy, wr_ready}, 0);
    FPGA_rst = 1'b1;
    tick();

    // Single-word write, both bytes enabled.
    send_cmd(1'b1, 20'h00010, 8'd0, 2'b11);
    chk("w1_wr_ready", wr_ready, 1);
    chk("w1_oe_before_word", mram_dq_oe, 0);
    chk("w1_lb_ub", {lb_en, ub_en}, 2'b00);
    wr_valid = 1'b1; wr_data = 16'hAAAA;
    tick();
    wr_valid = 1'b0;
    chk("w1_oe_setup", mram_dq_oe, 1);
    chk("w1_dq_out", mram_dq_out, 16'hAAAA);
    chk("w1_no_strobe_in_setup", write_en, 1);
    chk("w1_addr", mram_addr, 20'h00010);
    tick();
    cnt = 0;
    while (write_en == 1'b0 && cnt < 20) begin
      cnt++;
      if (cnt == 2) chk("w1_dq_in_pulse", mram_dq_out, 16'hAAAA);
      tick();
    end
    chk("w1_pulse_len", cnt, 4);
    chk("w1_oe_recover", {mram_dq_oe, chip_en, done}, 3'b100);
    tick();
    chk("w1_done", {done, aborted}, 2'b10);
    chk("w1_release", {chip_en, mram_dq_oe, lb_en, ub_en}, 4'b1011);
    chk("w1_cmd_ready_during_done", cmd_ready, 0);
    tick();
    chk("w1_done_single", done, 0);
    chk("w1_cmd_ready_after", cmd_ready, 1);

    // Asynchronous reset in the middle of a write strobe.
    send_cmd(1'b1, 20'h00040, 8'd0, 2'b11);
    wr_valid = 1'b1; wr_data = 16'h1234;
    tick();
    wr_valid = 1'b0;
    tick(); tick();
    chk("r_in_pulse", write_en, 0);
    #2 FPGA_rst = 1'b0;
    #1;
    chk("r_strobes", {chip_en, read_en, write_en, lb_en, ub_en}, 5'h1F);
    chk("r_oe", mram_dq_oe, 0);
    chk("r_done", done, 0);
    tick();
    FPGA_rst = 1'b1;
    tick(); tick();
    chk("r_after_release", {done, busy, cmd_ready}, 3'b001);

    // Read burst wrapping across the top of the address space.
    rd_ready = 1'b1;
    send_cmd(1'b0, 20'hFFFFE, 8'd3, 2'b11);
    wait_rd("rd_first_valid", lat);
    chk("rd_latency", lat, 5);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) wait_rd("rd_valid", lat);
      chk($sformatf("rd_data%0d", i), rd_data, exp_rd[i]);
      tick();
    end
    wait_done("rd_done");
    chk("rd_aborted", aborted, 0);
    tick();

    // Read held off by rd_ready.
    rd_ready = 1'b0;
    send_cmd(1'b0, 20'h00123, 8'd0, 2'b01);
    wait_rd("bp_valid", lat);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {rd_valid, read_en, rd_data}, {1'b1, 1'b1, 16'h0123});
      chk("bp_addr", mram_addr, 20'h00123);
      chk("bp_lb_ub", {lb_en, ub_en}, 2'b01);
      tick();
    end
    rd_ready = 1'b1;
    tick();
    chk("bp_dropped", rd_valid, 0);
    wait_done("bp_done");
    tick();

    // Two-word write with the second word late.
    send_cmd(1'b1, 20'h00200, 8'd1, 2'b01);
    wr_valid = 1'b1; wr_data = 16'h1111;
    tick();
    wr_valid = 1'b0;
    tick();
    wait_wr_ready("st_second_req");
    for (int i = 0; i < 5; i++) begin
      chk("st_starved", {chip_en, write_en, mram_dq_oe}, 3'b010);
      chk("st_addr", mram_addr, 20'h00201);
      tick();
    end
    wr_valid = 1'b1; wr_data = 16'h2222;
    tick();
    wr_valid = 1'b0;
    tick();
    chk("st_pulse", {write_en, mram_dq_oe}, 2'b01);
    chk("st_dq", mram_dq_out, 16'h2222);
    wait_done("st_done");
    chk("st_aborted", aborted, 0);
    tick();

    // Abort during the second cycle of the first write pulse of a 4-word burst.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    send_cmd(1'b1, 20'h00300, 8'd3, 2'b11);
    wr_valid = 1'b1; wr_data = 16'hBEEF;
    tick();
    wr_valid = 1'b0;
    tick();
    cnt = 0;
    if (!write_en) cnt++;
    tick();
    if (!write_en) cnt++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    while (write_en == 1'b0 && cnt < 20) begin cnt++; tick(); end
    chk("ab_pulse_len", cnt, 4);
    chk("ab_no_more_words", wr_ready, 0);
    wait_done("ab_done");
    chk("ab_aborted", aborted, 1);
    tick();
    chk("ab_idle", {busy, done, chip_en}, 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
